// File: rtl/buffer_pingpong_if.sv
// Load/aggregation-side signal bundle for the ping-pong feature buffer.
// The master modport is the load/agg side; the slave modport is the buffer.
interface buffer_pingpong_if #(
  parameter int BUFFER_ADDR_WIDTH = 11,
  parameter int BUFFER_DATA_WIDTH = 512
);
  logic                         load_write_addr_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr;
  logic [BUFFER_DATA_WIDTH-1:0] load_write_data;
  logic                         load_done;
  logic                         load_bank_ready;
  logic                         agg_read_addr_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] agg_read_addr;
  logic                         agg_read_data_valid;
  logic [BUFFER_DATA_WIDTH-1:0] agg_read_data;
  logic                         agg_done;
  logic                         agg_bank_ready;
  logic [1:0]                   bank_full;
  logic [2:0]                   err_flags;

  modport master (
    output load_write_addr_valid, load_write_addr, load_write_data, load_done,
    output agg_read_addr_valid, agg_read_addr, agg_done,
    input  load_bank_ready, agg_read_data_valid, agg_read_data, agg_bank_ready,
    input  bank_full, err_flags
  );

  modport slave (
    input  load_write_addr_valid, load_write_addr, load_write_data, load_done,
    input  agg_read_addr_valid, agg_read_addr, agg_done,
    output load_bank_ready, agg_read_data_valid, agg_read_data, agg_bank_ready,
    output bank_full, err_flags
  );
endinterface

// File: rtl/buffer_pingpong.sv
// Double-banked feature buffer: the load engine fills one bank of a shared
// 2x-deep simple-dual-port RAM while the aggregation engine reads the other.
module buffer_pingpong #(
  parameter int    BUFFER_ADDR_WIDTH  = 11,
  parameter int    BUFFER_DATA_WIDTH  = 512,
  parameter int    RAM_READ_LATENCY   = 2,
  parameter string MEM_POOL_PRIMITIVE = "auto"
) (
  input logic              clk,
  input logic              rst_n,
  buffer_pingpong_if.slave bus
);
  localparam int PAW   = BUFFER_ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** PAW;
  localparam int DW    = BUFFER_DATA_WIDTH;
  localparam int LAT   = RAM_READ_LATENCY;

  logic write_ok, load_done_ok, read_ok, agg_done_ok;
  logic wr_sel, rd_sel, wr_sel_next, rd_sel_next;
  logic [1:0] full_next;
  logic [2:0] err_next;

  logic           wr_vld_q, load_done_q;
  logic [PAW-1:0] wr_paddr_q;
  logic [DW-1:0]  wr_data_q;

  logic           rd_vld_q;
  logic [PAW-1:0] rd_paddr_q;
  logic [LAT-1:0] rd_vld_pipe;
  logic [DW-1:0]  rd_data_pipe [LAT];
  logic [DW-1:0]  ram_rd;

  assign write_ok     = bus.load_write_addr_valid & bus.load_bank_ready;
  assign load_done_ok = bus.load_done & bus.load_bank_ready;
  assign read_ok      = bus.agg_read_addr_valid & bus.agg_bank_ready;
  assign agg_done_ok  = bus.agg_done & bus.agg_bank_ready;

  // load_done is held back one stage so the bank closes on the edge the last write commits.
  always_comb begin
    full_next   = bus.bank_full;
    wr_sel_next = wr_sel;
    rd_sel_next = rd_sel;
    err_next    = bus.err_flags;
    if (load_done_q) begin
      full_next[wr_sel] = 1'b1;
      wr_sel_next       = ~wr_sel;
    end
    if (agg_done_ok) begin
      full_next[rd_sel] = 1'b0;
      rd_sel_next       = ~rd_sel;
    end
    err_next[0] = bus.err_flags[0] |
                  ((bus.load_write_addr_valid | bus.load_done) & ~bus.load_bank_ready);
    err_next[1] = bus.err_flags[1] |
                  ((bus.agg_read_addr_valid | bus.agg_done) & ~bus.agg_bank_ready);
    err_next[2] = bus.err_flags[2] |
                  (bus.load_done & ~bus.load_bank_ready & bus.agg_done & ~bus.agg_bank_ready);
  end

  // Ready drops while a close is pending so no write can slip into the closing bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel              <= 1'b0;
      rd_sel              <= 1'b0;
      bus.bank_full       <= 2'b00;
      bus.load_bank_ready <= 1'b1;
      bus.agg_bank_ready  <= 1'b0;
      bus.err_flags       <= 3'b000;
    end else begin
      wr_sel              <= wr_sel_next;
      rd_sel              <= rd_sel_next;
      bus.bank_full       <= full_next;
      bus.load_bank_ready <= ~full_next[wr_sel_next] & ~load_done_ok;
      bus.agg_bank_ready  <= full_next[rd_sel_next];
      bus.err_flags       <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_q    <= 1'b0;
      wr_paddr_q  <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_paddr_q  <= '0;
    end else begin
      wr_vld_q    <= write_ok;
      wr_paddr_q  <= {wr_sel, bus.load_write_addr};
      wr_data_q   <= bus.load_write_data;
      load_done_q <= load_done_ok;
      rd_vld_q    <= read_ok;
      rd_paddr_q  <= {rd_sel, bus.agg_read_addr};
    end
  end

  // The first pipe stage is the RAM read register; later stages model extra RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_pipe             <= '0;
      bus.agg_read_data_valid <= 1'b0;
      bus.agg_read_data       <= '0;
      for (int i = 0; i < LAT; i++) rd_data_pipe[i] <= '0;
    end else begin
      rd_vld_pipe[0] <= rd_vld_q;
      if (rd_vld_q) rd_data_pipe[0] <= ram_rd;
      for (int i = 1; i < LAT; i++) begin
        rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
        rd_data_pipe[i] <= rd_data_pipe[i-1];
      end
      bus.agg_read_data_valid <= rd_vld_pipe[LAT-1];
      bus.agg_read_data       <= rd_vld_pipe[LAT-1] ? rd_data_pipe[LAT-1] : '0;
    end
  end

  // Storage array; reading before the write lands on the same edge gives read-first behaviour.
  if (MEM_POOL_PRIMITIVE == "ultra") begin : g_uram
    (* ram_style = "ultra" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) if (wr_vld_q) mem[wr_paddr_q] <= wr_data_q;
    assign ram_rd = mem[rd_paddr_q];
  end else if (MEM_POOL_PRIMITIVE == "block") begin : g_bram
    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) if (wr_vld_q) mem[wr_paddr_q] <= wr_data_q;
    assign ram_rd = mem[rd_paddr_q];
  end else if (MEM_POOL_PRIMITIVE == "distributed") begin : g_lutram
    (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) if (wr_vld_q) mem[wr_paddr_q] <= wr_data_q;
    assign ram_rd = mem[rd_paddr_q];
  end else begin : g_auto
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) if (wr_vld_q) mem[wr_paddr_q] <= wr_data_q;
    assign ram_rd = mem[rd_paddr_q];
  end
endmodule

// File: tb/tb_buffer_pingpong.sv
// Directed bench for buffer_pingpong: bank swap handshake, read latency,
// dropped requests, sticky errors and mid-flight reset.
module tb_buffer_pingpong;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_pingpong_if #(.BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW)) bus ();

  buffer_pingpong #(
    .BUFFER_ADDR_WIDTH (AW),
    .BUFFER_DATA_WIDTH (DW),
    .RAM_READ_LATENCY  (LAT),
    .MEM_POOL_PRIMITIVE("auto")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic checkStatus(input string tag, input logic lbr, input logic abr,
                             input logic [1:0] full, input logic [2:0] err);
    logic [63:0] g, e;
    g = '0;
    e = '0;
    g[6:0] = {bus.load_bank_ready, bus.agg_bank_ready, bus.bank_full, bus.err_flags};
    e[6:0] = {lbr, abr, full, err};
    checkOutput(tag, g, e);
  endtask

  // Drives one cycle of inputs; returns at posedge+1 of the following cycle.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic ld, input logic rv, input logic [AW-1:0] ra,
                               input logic ad);
    bus.load_write_addr_valid = wv;
    bus.load_write_addr       = wa;
    bus.load_write_data       = wd;
    bus.load_done             = ld;
    bus.agg_read_addr_valid   = rv;
    bus.agg_read_addr         = ra;
    bus.agg_done              = ad;
    @(posedge clk);
    #1;
    bus.load_write_addr_valid = 1'b0;
    bus.load_write_addr       = '0;
    bus.load_write_data       = '0;
    bus.load_done             = 1'b0;
    bus.agg_read_addr_valid   = 1'b0;
    bus.agg_read_addr         = '0;
    bus.agg_done              = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic loadDone();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic aggDone();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Called in the cycle a read is presented; data is due LAT+2 cycles later.
  task automatic expectRead(input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = cyc + LAT + 2;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Read-port monitor: every cycle either the scheduled word or valid=0/data=0.
  initial begin
    logic [63:0] g, e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      g = '0;
      e = '0;
      g[DW:0] = {bus.agg_read_data_valid, bus.agg_read_data};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e[DW:0] = {1'b1, exp_q[0].data};
        void'(exp_q.pop_front());
        checkOutput("rdata", g, e);
      end else begin
        checkOutput("rd_idle", g, e);
      end
    end
  end

  initial begin
    logic [63:0] g;
    bus.load_write_addr_valid = 1'b0;
    bus.load_write_addr       = '0;
    bus.load_write_data       = '0;
    bus.load_done             = 1'b0;
    bus.agg_read_addr_valid   = 1'b0;
    bus.agg_read_addr         = '0;
    bus.agg_done              = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkStatus("reset", 1'b1, 1'b0, 2'b00, 3'b000);
    rst_n = 1'b1;

    // Fill bank 0 and close it.
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(32'hA0 + i));
    loadDone();
    checkStatus("close0_pending", 1'b0, 1'b0, 2'b00, 3'b000);
    idle(1);
    checkStatus("bank0_full", 1'b1, 1'b1, 2'b01, 3'b000);

    // Single read latency.
    expectRead(32'hA2);
    rd(4'd2);
    idle(6);

    // Overlap: fill bank 1 while draining bank 0, agg_done with the last read.
    for (int i = 0; i < 4; i++) begin
      expectRead(DW'(32'hA0 + i));
      applyStimulus(1'b1, AW'(i), DW'(32'hB0 + i), 1'b0, 1'b1, AW'(i), i == 3);
    end
    checkStatus("swap_rd", 1'b1, 1'b0, 2'b00, 3'b000);
    loadDone();
    idle(1);
    checkStatus("bank1_full", 1'b1, 1'b1, 2'b10, 3'b000);
    for (int i = 0; i < 4; i++) begin
      expectRead(DW'(32'hB0 + i));
      rd(AW'(i));
    end
    idle(6);

    // Both banks full; an extra write must be dropped.
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(32'hC0 + i));
    loadDone();
    idle(1);
    checkStatus("both_full", 1'b0, 1'b1, 2'b11, 3'b000);
    wr(4'd1, 32'hEE);
    checkStatus("drop_wr", 1'b0, 1'b1, 2'b11, 3'b001);
    expectRead(32'hB1);
    rd(4'd1);
    aggDone();
    checkStatus("release1", 1'b1, 1'b1, 2'b01, 3'b001);
    expectRead(32'hC2);
    rd(4'd2);
    aggDone();
    checkStatus("both_empty", 1'b1, 1'b0, 2'b00, 3'b001);
    idle(6);

    // Read and agg_done with nothing readable.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b1);
    checkStatus("illegal_rd", 1'b1, 1'b0, 2'b00, 3'b011);
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(32'hD0 + i));
    loadDone();
    checkStatus("close1_pending", 1'b0, 1'b0, 2'b00, 3'b011);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkStatus("dual_illegal", 1'b1, 1'b1, 2'b10, 3'b111);
    expectRead(32'hD3);
    rd(4'd3);
    idle(6);

    // Reset with three reads in flight.
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    rst_n = 1'b0;
    exp_q.delete();
    idle(2);
    checkStatus("in_reset", 1'b1, 1'b0, 2'b00, 3'b000);
    rst_n = 1'b1;
    idle(6);
    checkStatus("after_reset", 1'b1, 1'b0, 2'b00, 3'b000);

    g = 64'(exp_q.size());
    checkOutput("pending_reads", g, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
